// File: rtl/dnc_read_keys_pkg.sv
// dnc_read_keys shared types: FSM state enum, default sizes,
// size clamp and address-width helpers.
package dnc_read_keys_pkg;

  localparam int DEF_DATA_SIZE    = 64;
  localparam int DEF_CONTROL_SIZE = 64;
  localparam int DEF_R            = 64;
  localparam int DEF_W            = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

  function automatic logic [63:0] clamp(
    input logic [63:0] v,
    input logic [63:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dnc_read_keys_if.sv
// READ_KEYS handshake bundle: START/READY, sizes, input and output
// element streams. master = read-heads driver, slave = responder.
interface dnc_read_keys_if #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
);
  logic                    START;
  logic                    READY;
  logic [CONTROL_SIZE-1:0] SIZE_R_IN;
  logic [CONTROL_SIZE-1:0] SIZE_W_IN;
  logic                    K_IN_I_ENABLE;
  logic                    K_IN_K_ENABLE;
  logic [DATA_SIZE-1:0]    K_IN;
  logic                    K_OUT_I_ENABLE;
  logic                    K_OUT_K_ENABLE;
  logic [DATA_SIZE-1:0]    K_OUT;

  modport master (
    output START, SIZE_R_IN, SIZE_W_IN,
    output K_IN_I_ENABLE, K_IN_K_ENABLE, K_IN,
    input  READY, K_OUT_I_ENABLE, K_OUT_K_ENABLE, K_OUT
  );

  modport slave (
    input  START, SIZE_R_IN, SIZE_W_IN,
    input  K_IN_I_ENABLE, K_IN_K_ENABLE, K_IN,
    output READY, K_OUT_I_ENABLE, K_OUT_K_ENABLE, K_OUT
  );
endinterface

// File: rtl/dnc_read_keys_buffer.sv
// Single-port sync RAM, DEPTH x DATA_SIZE, registered read data.
// Ports: clk, rst_n, we, re, addr, wdata, rdata.
module dnc_read_keys_buffer
  import dnc_read_keys_pkg::*;
#(
  parameter int DEPTH     = DEF_R * DEF_W,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  localparam int AW       = addr_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        addr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dnc_read_keys.sv
// DNC read-keys responder: loads an sr x sw key matrix and returns it
// row-major. Ports: CLK, RST (async active-low), bus (slave).
// DNC_READ_KEYS_BUFFER_EN: buffered mode; undefined: cut-through.
module dnc_read_keys
  import dnc_read_keys_pkg::*;
#(
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int CONTROL_SIZE = DEF_CONTROL_SIZE,
  parameter int R            = DEF_R,
  parameter int W            = DEF_W
) (
  input logic           CLK,
  input logic           RST,
  dnc_read_keys_if.slave bus
);

  typedef logic [CONTROL_SIZE-1:0] cnt_t;

  localparam cnt_t ONE = cnt_t'(1);

  state_t state;
  cnt_t   sr, sw, i, k;
  cnt_t   i_nx, k_nx;
  cnt_t   sr_in, sw_in;
  logic   last_col, last;
  logic   ready_q, ien_q, ken_q;

  assign sr_in = cnt_t'(clamp(64'(bus.SIZE_R_IN), 64'(R)));
  assign sw_in = cnt_t'(clamp(64'(bus.SIZE_W_IN), 64'(W)));

  assign last_col = (k == sw - ONE);
  assign last     = last_col && (i == sr - ONE);

  always_comb begin
    i_nx = last_col ? i + ONE : i;
    k_nx = last_col ? '0 : k + ONE;
  end

  assign bus.READY          = ready_q;
  assign bus.K_OUT_I_ENABLE = ien_q;
  assign bus.K_OUT_K_ENABLE = ken_q;

`ifdef DNC_READ_KEYS_BUFFER_EN
  localparam int DEPTH = R * W;
  localparam int AW    = addr_w(DEPTH);

  logic [AW-1:0]        addr;
  logic [DATA_SIZE-1:0] rdata;
  logic [DATA_SIZE-1:0] head_q;
  logic                 sel_q;
  logic                 we, re;

  assign addr = AW'(i * cnt_t'(W) + k);
  assign we   = (state == S_LOAD) && bus.K_IN_K_ENABLE;
  assign re   = (state == S_EMIT);

  // Element 0 is held aside so the first output can leave the cycle
  // after the last write, before the RAM port is free to read.
  assign bus.K_OUT = !ken_q ? '0 : sel_q ? head_q : rdata;

  dnc_read_keys_buffer #(
    .DEPTH    (DEPTH),
    .DATA_SIZE(DATA_SIZE)
  ) u_buf (
    .clk  (CLK),
    .rst_n(RST),
    .we   (we),
    .re   (re),
    .addr (addr),
    .wdata(bus.K_IN),
    .rdata(rdata)
  );
`else
  logic [DATA_SIZE-1:0] kout_q;

  assign bus.K_OUT = kout_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      sr      <= '0;
      sw      <= '0;
      i       <= '0;
      k       <= '0;
      ready_q <= 1'b0;
      ien_q   <= 1'b0;
      ken_q   <= 1'b0;
`ifdef DNC_READ_KEYS_BUFFER_EN
      head_q  <= '0;
      sel_q   <= 1'b0;
`else
      kout_q  <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      ien_q   <= 1'b0;
      ken_q   <= 1'b0;
`ifndef DNC_READ_KEYS_BUFFER_EN
      kout_q  <= '0;
`endif
      unique case (state)
        S_IDLE: begin
          if (bus.START) begin
            sr <= sr_in;
            sw <= sw_in;
            i  <= '0;
            k  <= '0;
            if (sr_in == '0 || sw_in == '0) state <= S_DONE;
            else                            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.K_IN_K_ENABLE) begin
`ifdef DNC_READ_KEYS_BUFFER_EN
            if (i == '0 && k == '0) head_q <= bus.K_IN;
            if (last) begin
              // Output regs take element 0 now; counters point at the
              // next element so its read is issued one cycle ahead.
              ken_q <= 1'b1;
              ien_q <= 1'b1;
              sel_q <= 1'b1;
              i     <= (sw == ONE) ? ONE : '0;
              k     <= (sw == ONE) ? '0 : ONE;
              state <= (i == '0 && k == '0) ? S_DONE : S_EMIT;
            end else begin
              i <= i_nx;
              k <= k_nx;
            end
`else
            ken_q  <= 1'b1;
            ien_q  <= (k == '0);
            kout_q <= bus.K_IN;
            if (last) begin
              i     <= '0;
              k     <= '0;
              state <= S_DONE;
            end else begin
              i <= i_nx;
              k <= k_nx;
            end
`endif
          end
        end
        S_EMIT: begin
`ifdef DNC_READ_KEYS_BUFFER_EN
          ken_q <= 1'b1;
          ien_q <= (k == '0);
          sel_q <= 1'b0;
          if (last) begin
            state <= S_DONE;
          end else begin
            i <= i_nx;
            k <= k_nx;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_DONE: begin
          ready_q <= 1'b1;
          i       <= '0;
          k       <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dnc_read_keys.sv
// Bench for dnc_read_keys: per-cycle expectation tables built from the
// transfer rules, compared against the DUT every cycle.
module tb_dnc_read_keys;

  localparam int DS = 32;
  localparam int CS = 16;
  localparam int RR = 4;
  localparam int WW = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  dnc_read_keys_if #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) bus ();

  dnc_read_keys #(
    .DATA_SIZE   (DS),
    .CONTROL_SIZE(CS),
    .R           (RR),
    .W           (WW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  bit            e_ken  [int];
  bit            e_ien  [int];
  bit            e_rdy  [int];
  logic [DS-1:0] e_kout [int];

  task automatic chk(input string nm, input logic [DS-1:0] act,
                     input logic [DS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic expect_at(input int c, input bit ken, input bit ien,
                           input logic [DS-1:0] kout, input bit rdy);
    e_ken[c]  = ken;
    e_ien[c]  = ien;
    e_kout[c] = kout;
    e_rdy[c]  = rdy;
  endtask

  task automatic purge(input int from);
    int ks[$];
    foreach (e_ken[key]) if (key >= from) ks.push_back(key);
    foreach (ks[j]) begin
      e_ken.delete(ks[j]);
      e_ien.delete(ks[j]);
      e_kout.delete(ks[j]);
      e_rdy.delete(ks[j]);
    end
  endtask

  always @(negedge CLK) begin
    chk("ready", DS'(bus.READY),
        DS'(e_rdy.exists(cyc) ? e_rdy[cyc] : 1'b0));
    chk("k_en", DS'(bus.K_OUT_K_ENABLE),
        DS'(e_ken.exists(cyc) ? e_ken[cyc] : 1'b0));
    chk("i_en", DS'(bus.K_OUT_I_ENABLE),
        DS'(e_ien.exists(cyc) ? e_ien[cyc] : 1'b0));
    chk("k_out", bus.K_OUT,
        e_kout.exists(cyc) ? e_kout[cyc] : '0);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // gap >= 0: fixed idle cycles before each element; gap < 0: random
  // 0..-gap. base >= 0: values base+1, base+2, ...; else random.
  task automatic xfer(input int rin, input int win, input int gap,
                      input int base, input int nextra, input int abort_at,
                      input bit mid_start, output int c0, output int lc);
    int sr, sw, n, acc, g, rdy;
    logic [DS-1:0] v;
    logic [DS-1:0] vals[$];
    sr  = (rin < RR) ? rin : RR;
    sw  = (win < WW) ? win : WW;
    n   = sr * sw;
    acc = 0;
    lc  = -1;
    bus.START     = 1'b1;
    bus.SIZE_R_IN = CS'(rin);
    bus.SIZE_W_IN = CS'(win);
    c0 = cyc;
    step();
    bus.START     = 1'b0;
    bus.SIZE_R_IN = CS'($urandom);
    bus.SIZE_W_IN = CS'($urandom);
    if (n == 0) begin
      rdy = c0 + 2;
      expect_at(rdy, 1'b0, 1'b0, '0, 1'b1);
      while (cyc <= rdy) step();
      return;
    end
    while (acc < n) begin
      g = (gap >= 0) ? gap : $urandom_range(-gap, 0);
      repeat (g) begin
        bus.K_IN_K_ENABLE = 1'b0;
        bus.K_IN_I_ENABLE = 1'($urandom);
        bus.K_IN          = DS'($urandom);
        step();
      end
      v = (base >= 0) ? DS'(base + acc + 1) : DS'($urandom);
      bus.K_IN_K_ENABLE = 1'b1;
      bus.K_IN_I_ENABLE = (acc % sw == 0);
      bus.K_IN          = v;
`ifndef DNC_READ_KEYS_BUFFER_EN
      expect_at(cyc + 1, 1'b1, (acc % sw == 0), v, 1'b0);
`endif
      vals.push_back(v);
      lc = cyc;
      acc++;
      step();
      if (acc == abort_at) begin
        bus.K_IN_K_ENABLE = 1'b0;
        purge(cyc);
        RST = 1'b0;
        step();
        step();
        RST = 1'b1;
        step();
        return;
      end
    end
`ifdef DNC_READ_KEYS_BUFFER_EN
    for (int j = 0; j < n; j++)
      expect_at(lc + 1 + j, 1'b1, (j % sw == 0), vals[j], 1'b0);
    rdy = lc + n + 1;
`else
    rdy = lc + 2;
`endif
    expect_at(rdy, 1'b0, 1'b0, '0, 1'b1);
    for (int e = 0; e < ((nextra > 1) ? nextra : 1); e++) begin
      bus.K_IN_K_ENABLE = (e < nextra);
      bus.K_IN          = DS'($urandom);
      bus.START         = (e == 0) && mid_start;
      bus.SIZE_R_IN     = CS'(1);
      bus.SIZE_W_IN     = CS'(1);
      step();
    end
    bus.START         = 1'b0;
    bus.K_IN_K_ENABLE = 1'b0;
    while (cyc <= rdy) step();
  endtask

  initial begin
    int c0, lc;
    bus.START         = 1'b0;
    bus.SIZE_R_IN     = '0;
    bus.SIZE_W_IN     = '0;
    bus.K_IN_I_ENABLE = 1'b0;
    bus.K_IN_K_ENABLE = 1'b0;
    bus.K_IN          = '0;
    step();
    step();
    chk("rst_ready", DS'(bus.READY), '0);
    chk("rst_k_en", DS'(bus.K_OUT_K_ENABLE), '0);
    chk("rst_i_en", DS'(bus.K_OUT_I_ENABLE), '0);
    chk("rst_k_out", bus.K_OUT, '0);
    RST = 1'b1;
    step();

    // 2x3, values 1..6 back to back
    xfer(2, 3, 0, 0, 0, 0, 1'b0, c0, lc);
    chk("pin_last_in", DS'(lc), DS'(c0 + 6));
`ifdef DNC_READ_KEYS_BUFFER_EN
    chk("pin_first_out", e_kout[lc + 1], DS'(1));
    chk("pin_last_out", e_kout[lc + 6], DS'(6));
    chk("pin_row1", DS'(e_ien[lc + 4]), DS'(1));
    chk("pin_ready", DS'(e_rdy[lc + 7]), DS'(1));
`else
    chk("pin_first_out", e_kout[lc - 4], DS'(1));
    chk("pin_last_out", e_kout[lc + 1], DS'(6));
    chk("pin_row1", DS'(e_ien[lc - 1]), DS'(1));
    chk("pin_ready", DS'(e_rdy[lc + 2]), DS'(1));
`endif

    // same transfer, two idle cycles between elements
    xfer(2, 3, 2, 0, 0, 0, 1'b0, c0, lc);
    // zero rows
    xfer(0, 5, 0, 0, 0, 0, 1'b0, c0, lc);
    chk("pin_zero_ready", DS'(e_rdy[c0 + 2]), DS'(1));
    // oversize clamp, 17th element offered and dropped
    xfer(9, 9, 0, 100, 1, 0, 1'b0, c0, lc);
    // abort after 3 of 6, then 2x2 with START during output
    xfer(2, 3, 0, 0, 0, 3, 1'b0, c0, lc);
    xfer(2, 2, 0, 6, 0, 0, 1'b1, c0, lc);
    // 1x1 edge case
    xfer(1, 1, 0, 40, 2, 0, 1'b1, c0, lc);

    for (int t = 0; t < 30; t++) begin
      xfer($urandom_range(6, 0), $urandom_range(6, 0), -2, -1,
           $urandom_range(2, 0), 0, 1'($urandom), c0, lc);
      repeat ($urandom_range(2, 0)) step();
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
